// File: rtl/wb_sdram_pkg.sv
// Shared types and constants for the Wishbone-to-SDRAM-controller bridge.
package wb_sdram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WAIT_RD  = 3'd2,
      ST_MERGE    = 3'd3,
      ST_ISSUE_WR = 3'd4,
      ST_RESP     = 3'd5
   } state_e;

   localparam int WIN_MSB = 31;
   localparam int WIN_LSB = 23;
   localparam int CTL_AW  = 23;

endpackage

// File: rtl/wb_sdram_byte_merge.sv
// Combinational byte-lane merge for read-modify-write: selected lanes take
// the new bus data, the rest keep the word read back from SDRAM.
module wb_sdram_byte_merge (
   input  logic [3:0]  sel_i,
   input  logic [31:0] new_i,
   input  logic [31:0] old_i,
   output logic [31:0] merged_o
);

   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign merged_o[8*k +: 8] = sel_i[k] ? new_i[8*k +: 8] : old_i[8*k +: 8];
   end

endmodule

// File: rtl/wb_sdram_bridge.sv
// Wishbone classic slave turning bus cycles into single-word SDRAM controller
// requests, with RMW for partial writes and a read-response timeout.
module wb_sdram_bridge
   import wb_sdram_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h3800_0000,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic              wbs_err_o,
   output logic [31:0]       wbs_dat_o,
   output logic [CTL_AW-1:0] ctl_addr,
   output logic              ctl_rw,
   output logic [31:0]       ctl_wdata,
   output logic              ctl_in_valid,
   input  logic              ctl_busy,
   input  logic [31:0]       ctl_rdata,
   input  logic              ctl_out_valid
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   state_e            state_q, state_d;
   logic [CTL_AW-1:0] adr_q, adr_d;
   logic [31:0]       dat_q, dat_d, old_q, old_d, rdat_q, rdat_d, merged;
   logic [3:0]        sel_q, sel_d;
   logic              rw_q, rw_d, rmw_q, rmw_d, abort_q, abort_d;
   logic              vld_q, vld_d, gap_q, ack_q, ack_d, err_q, err_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              req, hit, can_pulse, tmo_hit;
   logic              unused_adr_lsb;

   assign req            = wbs_cyc_i & wbs_stb_i;
   assign hit            = wbs_adr_i[WIN_MSB:WIN_LSB] == BASE_ADDR[WIN_MSB:WIN_LSB];
   assign tmo_hit        = tmo_q == TW'(TIMEOUT_CYCLES - 1);
   assign unused_adr_lsb = ^wbs_adr_i[1:0];
   // Busy is seen a cycle late, so the two cycles after a pulse are blocked
   // outright; an aborted read still owns the controller until it resolves.
   assign can_pulse = !ctl_busy && !vld_q && !gap_q && !abort_q;

   wb_sdram_byte_merge u_merge (
      .sel_i    (sel_q),
      .new_i    (dat_q),
      .old_i    (old_q),
      .merged_o (merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req) begin
            if (!hit || (wbs_we_i && wbs_sel_i == 4'h0)) state_d = ST_RESP;
            else                                         state_d = ST_ISSUE;
         end
         ST_ISSUE, ST_ISSUE_WR: begin
            if (!wbs_cyc_i) state_d = ST_IDLE;
            else if (vld_q) state_d = rw_q ? ST_RESP : ST_WAIT_RD;
         end
         ST_WAIT_RD: begin
            if (!wbs_cyc_i)         state_d = ST_IDLE;
            else if (ctl_out_valid) state_d = rmw_q ? ST_MERGE : ST_RESP;
            else if (tmo_hit)       state_d = ST_RESP;
         end
         ST_MERGE: state_d = wbs_cyc_i ? ST_ISSUE_WR : ST_IDLE;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      old_d   = old_q;
      rdat_d  = rdat_q;
      rw_d    = rw_q;
      rmw_d   = rmw_q;
      abort_d = abort_q;
      tmo_d   = tmo_q;
      vld_d   = 1'b0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      if (abort_q) begin
         tmo_d = tmo_q + TW'(1);
         if (ctl_out_valid || tmo_hit) abort_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: if (req) begin
            if (!hit) begin
               err_d  = 1'b1;
               rdat_d = '0;
            end else if (wbs_we_i && wbs_sel_i == 4'h0) begin
               ack_d = 1'b1;
            end else begin
               adr_d = {wbs_adr_i[CTL_AW-1:2], 2'b00};
               dat_d = wbs_dat_i;
               sel_d = wbs_sel_i;
               rw_d  = wbs_we_i && (wbs_sel_i == 4'hF);
               rmw_d = wbs_we_i && (wbs_sel_i != 4'hF);
               vld_d = can_pulse;
            end
         end
         ST_ISSUE, ST_ISSUE_WR: begin
            if (vld_q) begin
               // Counter holds cycles elapsed since the read pulse.
               if (!rw_q)                    tmo_d   = TW'(1);
               if (!wbs_cyc_i && !rw_q)      abort_d = 1'b1;
               else if (wbs_cyc_i && rw_q)   ack_d   = 1'b1;
            end else if (wbs_cyc_i) begin
               vld_d = can_pulse;
            end
         end
         ST_WAIT_RD: begin
            tmo_d = tmo_q + TW'(1);
            if (ctl_out_valid) begin
               if (wbs_cyc_i) begin
                  if (rmw_q) old_d = ctl_rdata;
                  else begin
                     ack_d  = 1'b1;
                     rdat_d = ctl_rdata;
                  end
               end
            end else if (!wbs_cyc_i) begin
               if (!tmo_hit) abort_d = 1'b1;
            end else if (tmo_hit) begin
               err_d  = 1'b1;
               rdat_d = '0;
            end
         end
         ST_MERGE: if (wbs_cyc_i) begin
            dat_d = merged;
            rw_d  = 1'b1;
            vld_d = can_pulse;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         old_q   <= '0;
         rdat_q  <= '0;
         rw_q    <= 1'b0;
         rmw_q   <= 1'b0;
         abort_q <= 1'b0;
         tmo_q   <= '0;
         vld_q   <= 1'b0;
         gap_q   <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         old_q   <= old_d;
         rdat_q  <= rdat_d;
         rw_q    <= rw_d;
         rmw_q   <= rmw_d;
         abort_q <= abort_d;
         tmo_q   <= tmo_d;
         vld_q   <= vld_d;
         gap_q   <= vld_q;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign wbs_ack_o    = ack_q;
   assign wbs_err_o    = err_q;
   assign wbs_dat_o    = rdat_q;
   assign ctl_addr     = adr_q;
   assign ctl_rw       = rw_q;
   assign ctl_wdata    = dat_q;
   assign ctl_in_valid = vld_q;

endmodule

// File: tb/tb_wb_sdram_bridge.sv
// Directed bench for wb_sdram_bridge: a controller model plus scoreboards for
// expected controller pulses and expected Wishbone responses.
module tb_wb_sdram_bridge;

   localparam int TMO = 256;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        wbs_cyc_i = 0, wbs_stb_i = 0, wbs_we_i = 0;
   logic [3:0]  wbs_sel_i = '0;
   logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
   logic        wbs_ack_o, wbs_err_o;
   logic [31:0] wbs_dat_o;
   logic [22:0] ctl_addr;
   logic        ctl_rw, ctl_in_valid;
   logic [31:0] ctl_wdata;
   logic        ctl_busy = 0, ctl_out_valid = 0;
   logic [31:0] ctl_rdata = '0;

   always #5 clk = ~clk;

   wb_sdram_bridge #(.BASE_ADDR(32'h3800_0000), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
      .ctl_addr(ctl_addr), .ctl_rw(ctl_rw), .ctl_wdata(ctl_wdata),
      .ctl_in_valid(ctl_in_valid), .ctl_busy(ctl_busy),
      .ctl_rdata(ctl_rdata), .ctl_out_valid(ctl_out_valid)
   );

   typedef struct {
      string tag; logic is_err; logic chk_dat; logic [31:0] dat; int cyc;
   } resp_t;
   typedef struct {
      string tag; logic [22:0] addr; logic rw; logic chk_wd; logic [31:0] wdata; int cyc;
   } ctl_t;

   resp_t       rq[$];
   ctl_t        cq[$];
   int          n_cmp = 0, n_bad = 0, cyc_n = 0, last_pulse = -100, n_resp = 0;
   bit          resp_seen = 0, force_busy = 0, drop_resp = 0;
   logic [31:0] mem [int];
   int          rd_cnt = 0, bsy_cnt = 0, rd_delay = 4;
   logic [22:0] rd_addr = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mrd(input int a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   task automatic exp_resp(input string tag, input logic is_err, input logic chk_dat,
                           input logic [31:0] dat, input int cyc);
      resp_t r;
      r = '{tag, is_err, chk_dat, dat, cyc};
      rq.push_back(r);
   endtask

   task automatic exp_ctl(input string tag, input logic [22:0] addr, input logic rw,
                          input logic chk_wd, input logic [31:0] wdata, input int cyc);
      ctl_t c;
      c = '{tag, addr, rw, chk_wd, wdata, cyc};
      cq.push_back(c);
   endtask

   // One cycle: sample DUT outputs mid-cycle, then drive the controller model.
   task automatic tick();
      resp_t r;
      ctl_t  c;
      @(negedge clk);
      cyc_n++;
      resp_seen = 0;
      if (ctl_in_valid) begin
         if (cq.size() == 0) chk("unexpected_pulse", 32'(ctl_addr), 32'h7FFFFF);
         else begin
            c = cq.pop_front();
            chk({c.tag, "_addr"}, 32'(ctl_addr), 32'(c.addr));
            chk({c.tag, "_rw"}, 32'(ctl_rw), 32'(c.rw));
            if (c.chk_wd) chk({c.tag, "_wdata"}, ctl_wdata, c.wdata);
            if (c.cyc >= 0) chk({c.tag, "_pulse_cyc"}, 32'(cyc_n), 32'(c.cyc));
         end
         chk("pulse_gap", 32'(cyc_n - last_pulse >= 3), 32'd1);
         last_pulse = cyc_n;
      end
      if (wbs_ack_o || wbs_err_o) begin
         resp_seen = 1;
         n_resp++;
         chk("ack_err_exclusive", 32'(wbs_ack_o & wbs_err_o), 32'd0);
         if (rq.size() == 0) chk("unexpected_resp", {30'd0, wbs_ack_o, wbs_err_o}, 32'd0);
         else begin
            r = rq.pop_front();
            chk({r.tag, "_err"}, 32'(wbs_err_o), 32'(r.is_err));
            chk({r.tag, "_ack"}, 32'(wbs_ack_o), 32'(!r.is_err));
            if (r.chk_dat) chk({r.tag, "_dat"}, wbs_dat_o, r.dat);
            if (r.cyc >= 0) chk({r.tag, "_resp_cyc"}, 32'(cyc_n), 32'(r.cyc));
         end
      end
      ctl_out_valid = 1'b0;
      if (bsy_cnt > 0) bsy_cnt--;
      if (rd_cnt > 0) begin
         rd_cnt--;
         if (rd_cnt == 0) begin
            ctl_out_valid = 1'b1;
            ctl_rdata     = mrd(int'(rd_addr));
         end
      end
      if (ctl_in_valid && rst_n) begin
         if (ctl_rw) mem[int'(ctl_addr)] = ctl_wdata;
         else if (!drop_resp) begin
            rd_cnt  = rd_delay;
            rd_addr = ctl_addr;
         end
         bsy_cnt = 3;
      end
      ctl_busy = force_busy || (bsy_cnt inside {[1:2]});
   endtask

   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int busy_ticks, input int budget);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
      wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
      if (busy_ticks > 0) begin
         repeat (busy_ticks) tick();
         force_busy = 0;
         ctl_busy   = 0;
      end
      for (int i = 0; i < budget; i++) begin
         tick();
         if (resp_seen) break;
      end
      chk("xfer_completed", 32'(resp_seen), 32'd1);
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
   endtask

   int t0, snap;

   initial begin
      repeat (3) tick();
      chk("rst_ack", 32'(wbs_ack_o), 0);
      chk("rst_err", 32'(wbs_err_o), 0);
      chk("rst_dat", wbs_dat_o, 0);
      chk("rst_in_valid", 32'(ctl_in_valid), 0);
      chk("rst_addr", 32'(ctl_addr), 0);
      chk("rst_rw", 32'(ctl_rw), 0);
      chk("rst_wdata", ctl_wdata, 0);
      rst_n = 1;
      repeat (2) tick();

      t0 = cyc_n;
      exp_ctl("wr_full", 23'h40, 1, 1, 32'hDEADBEEF, t0 + 1);
      exp_resp("wr_full", 0, 0, 0, t0 + 2);
      wb_xfer(1, 32'h3800_0040, 32'hDEADBEEF, 4'hF, 0, 20);
      repeat (3) tick();

      rd_delay = 4; t0 = cyc_n;
      exp_ctl("rd_cas4", 23'h40, 0, 0, 0, t0 + 1);
      exp_resp("rd_cas4", 0, 1, 32'hDEADBEEF, t0 + 6);
      wb_xfer(0, 32'h3800_0040, 32'h0, 4'hF, 0, 20);
      repeat (3) tick();

      rd_delay = 1; t0 = cyc_n;
      exp_ctl("rd_hit", 23'h40, 0, 0, 0, t0 + 1);
      exp_resp("rd_hit", 0, 1, 32'hDEADBEEF, t0 + 3);
      wb_xfer(0, 32'h3800_0040, 32'h0, 4'hF, 0, 20);
      repeat (3) tick();

      t0 = cyc_n;
      exp_ctl("wr_seed", 23'h44, 1, 1, 32'h11223344, t0 + 1);
      exp_resp("wr_seed", 0, 0, 0, t0 + 2);
      wb_xfer(1, 32'h3800_0044, 32'h11223344, 4'hF, 0, 20);
      repeat (3) tick();

      rd_delay = 2;
      exp_ctl("rmw_rd", 23'h44, 0, 0, 0, -1);
      exp_ctl("rmw_wr", 23'h44, 1, 1, 32'h11225544, -1);
      exp_resp("rmw", 0, 0, 0, -1);
      wb_xfer(1, 32'h3800_0044, 32'h0000_5500, 4'b0010, 0, 40);
      repeat (3) tick();

      t0 = cyc_n;
      exp_ctl("rmw_chk_rd", 23'h44, 0, 0, 0, t0 + 1);
      exp_resp("rmw_chk_rd", 0, 1, 32'h11225544, t0 + 4);
      wb_xfer(0, 32'h3800_0044, 32'h0, 4'hF, 0, 20);
      repeat (3) tick();

      t0 = cyc_n;
      exp_resp("wr_sel0", 0, 0, 0, t0 + 1);
      wb_xfer(1, 32'h3800_0048, 32'hFFFF_FFFF, 4'h0, 0, 20);
      repeat (3) tick();

      t0 = cyc_n;
      exp_resp("miss", 1, 0, 0, t0 + 1);
      wb_xfer(0, 32'h3000_0000, 32'h0, 4'hF, 0, 20);
      repeat (3) tick();

      drop_resp = 1; t0 = cyc_n;
      exp_ctl("tmo_rd", 23'h40, 0, 0, 0, t0 + 1);
      exp_resp("tmo", 1, 1, 32'h0, t0 + 1 + TMO);
      wb_xfer(0, 32'h3800_0040, 32'h0, 4'hF, 0, TMO + 20);
      drop_resp = 0;
      repeat (3) tick();

      rd_delay = 3; t0 = cyc_n;
      exp_ctl("post_tmo_rd", 23'h40, 0, 0, 0, t0 + 1);
      exp_resp("post_tmo_rd", 0, 1, 32'hDEADBEEF, t0 + 5);
      wb_xfer(0, 32'h3800_0040, 32'h0, 4'hF, 0, 20);
      repeat (3) tick();

      force_busy = 1; ctl_busy = 1; t0 = cyc_n;
      exp_ctl("busy_wr", 23'h50, 1, 1, 32'hCAFEF00D, t0 + 21);
      exp_resp("busy_wr", 0, 0, 0, t0 + 22);
      wb_xfer(1, 32'h3800_0050, 32'hCAFEF00D, 4'hF, 20, 20);
      repeat (3) tick();

      rd_delay = 10; t0 = cyc_n;
      exp_ctl("abort_rd", 23'h40, 0, 0, 0, t0 + 1);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0;
      wbs_adr_i = 32'h3800_0040; wbs_sel_i = 4'hF;
      repeat (4) tick();
      wbs_cyc_i = 0; wbs_stb_i = 0;
      snap = n_resp;
      repeat (12) tick();
      chk("abort_no_resp", 32'(n_resp), 32'(snap));

      rd_delay = 1; t0 = cyc_n;
      exp_ctl("post_abort_rd", 23'h44, 0, 0, 0, t0 + 1);
      exp_resp("post_abort_rd", 0, 1, 32'h11225544, t0 + 3);
      wb_xfer(0, 32'h3800_0044, 32'h0, 4'hF, 0, 20);
      repeat (3) tick();

      force_busy = 1; ctl_busy = 1;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1;
      wbs_adr_i = 32'h3800_0060; wbs_dat_i = 32'h1234_5678; wbs_sel_i = 4'hF;
      repeat (3) tick();
      rst_n = 0; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      snap = last_pulse;
      tick();
      chk("rst_mid_in_valid", 32'(ctl_in_valid), 0);
      chk("rst_mid_ack", 32'(wbs_ack_o), 0);
      force_busy = 0; rst_n = 1;
      repeat (6) tick();
      chk("rst_mid_no_pulse", 32'(last_pulse), 32'(snap));

      chk("ctl_queue_empty", 32'(cq.size()), 0);
      chk("resp_queue_empty", 32'(rq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
